// File: rtl/cspi_pkg.sv
// Shared definitions for the control SPI responder: frame size, FSM states
// and default device/broadcast/status bytes.
package cspi_pkg;

    localparam int FRAME_BITS = 32;

    localparam logic [7:0] DEF_DEV_ID   = 8'h01;
    localparam logic [7:0] DEF_BCAST_ID = 8'hFF;
    localparam logic [7:0] DEF_STATUS   = 8'hA5;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2
    } state_t;

endpackage

// File: rtl/cspi_sync_edge.sv
// Two-flop synchronizer for one asynchronous SPI pin, followed by a
// registered edge detector producing one-cycle rise/fall pulses.
module cspi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic prev;

    // Bring the pin into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    // Compare against the previous synchronized value; pulses are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= RST_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            prev <= s2;
            rise <= s2 & ~prev;
            fall <= ~s2 & prev;
        end
    end

    assign lvl = s2;

endmodule

// File: rtl/cspi_slave.sv
// Control SPI responder: oversamples csn/sck/mosi with clk_sys, shifts in
// 32-bit command frames, filters them by device ID and strobes cmd_vld.
// MISO returns STATUS followed by a one-byte-delayed echo of the frame.
module cspi_slave
    import cspi_pkg::*;
#(
    parameter logic [7:0] DEV_ID   = DEF_DEV_ID,
    parameter logic [7:0] BCAST_ID = DEF_BCAST_ID,
    parameter logic [7:0] STATUS   = DEF_STATUS
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       cspi_csn,
    input  logic       cspi_sck,
    input  logic       cspi_mosi,
    output logic       cspi_miso,
    output logic [7:0] cmd_dev_id,
    output logic [7:0] cmd_mod_id,
    output logic [7:0] cmd_addr,
    output logic [7:0] cmd_data,
    output logic       cmd_vld,
    output logic       frm_err,
    output state_t     fsm_state
);

    localparam logic [5:0] CNT_FULL = 6'(FRAME_BITS);
    localparam logic [5:0] CNT_SAT  = 6'(FRAME_BITS + 1);

    logic csn_lvl, csn_rise, csn_fall;
    logic sck_lvl, sck_rise, sck_fall;
    logic mosi_s1, mosi_s2;

    state_t      state, next_state;
    logic [5:0]  bit_cnt;
    logic [31:0] rx;
    logic [7:0]  tx;
    logic [1:0]  settle_cnt;

    logic bus_idle;
    logic id_match;
    logic start, shift_rx, shift_tx, accept, bad_len;

    cspi_sync_edge #(.RST_VAL(1'b1)) u_csn (
        .clk  (clk_sys),
        .rst  (rst),
        .din  (cspi_csn),
        .lvl  (csn_lvl),
        .rise (csn_rise),
        .fall (csn_fall)
    );

    cspi_sync_edge #(.RST_VAL(1'b0)) u_sck (
        .clk  (clk_sys),
        .rst  (rst),
        .din  (cspi_sck),
        .lvl  (sck_lvl),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    // MOSI only needs synchronizing; it is sampled on the sck rise pulse.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            mosi_s1 <= cspi_mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    // Bus idle = deselected with sck at its mode-0 rest level.
    assign bus_idle = csn_lvl & ~sck_lvl;
    assign id_match = (rx[31:24] == DEV_ID) || (rx[31:24] == BCAST_ID);

    // State register.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) state <= WAIT_IDLE;
        else     state <= next_state;
    end

    // Next state and per-cycle datapath controls; csn rise beats any sck edge.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        shift_rx   = 1'b0;
        shift_tx   = 1'b0;
        accept     = 1'b0;
        bad_len    = 1'b0;
        case (state)
            WAIT_IDLE: begin
                // Synchronizer flops reset high, so require three consecutive
                // idle samples: a csn held low through reset is not mistaken
                // for a fresh frame start.
                if (bus_idle && settle_cnt == 2'd2) next_state = IDLE;
            end
            IDLE: begin
                if (csn_fall) begin
                    next_state = SHIFT;
                    start      = 1'b1;
                end
            end
            SHIFT: begin
                if (csn_rise) begin
                    next_state = IDLE;
                    if (bit_cnt == CNT_FULL) accept  = id_match;
                    else                     bad_len = 1'b1;
                end else begin
                    shift_rx = sck_rise;
                    shift_tx = sck_fall;
                end
            end
            default: next_state = WAIT_IDLE;
        endcase
    end

    // Count consecutive idle cycles while waiting for a clean bus.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            settle_cnt <= 2'd0;
        end else if (state == WAIT_IDLE && bus_idle) begin
            if (settle_cnt != 2'd2) settle_cnt <= settle_cnt + 2'd1;
        end else begin
            settle_cnt <= 2'd0;
        end
    end

    // Receive side: bit counter (saturating) and rx shifter.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            bit_cnt <= 6'd0;
            rx      <= 32'd0;
        end else if (start) begin
            bit_cnt <= 6'd0;
        end else if (shift_rx) begin
            rx <= {rx[30:0], mosi_s2};
            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 6'd1;
        end
    end

    // Transmit side: STATUS first, then echo each completed byte.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            tx <= 8'd0;
        end else if (start) begin
            tx <= STATUS;
        end else if (shift_tx) begin
            if (bit_cnt == 6'd8 || bit_cnt == 6'd16 || bit_cnt == 6'd24) tx <= rx[7:0];
            else                                                          tx <= {tx[6:0], 1'b0};
        end
    end

    // Command outputs: fields hold until the next accepted frame.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            cmd_dev_id <= 8'd0;
            cmd_mod_id <= 8'd0;
            cmd_addr   <= 8'd0;
            cmd_data   <= 8'd0;
            cmd_vld    <= 1'b0;
            frm_err    <= 1'b0;
        end else begin
            cmd_vld <= accept;
            frm_err <= bad_len;
            if (accept) begin
                cmd_dev_id <= rx[31:24];
                cmd_mod_id <= rx[23:16];
                cmd_addr   <= rx[15:8];
                cmd_data   <= rx[7:0];
            end
        end
    end

    assign cspi_miso = (state == SHIFT) ? tx[7] : 1'b0;
    assign fsm_state = state;

endmodule
